// File: rtl/mult_seq.sv
// Iterative WIDTH x WIDTH signed/unsigned multiplier, sign-magnitude shift-add, one partial product per clock.
// Latency: accept edge E0, result on z_o with a one-cycle done_o pulse at edge E0+WIDTH+1; busy_o covers WIDTH+1 cycles.
// Backpressure: start_i is only sampled while idle; requests made while busy_o is high are dropped, not queued.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               sign_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic [2*WIDTH-1:0] z_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_mag_q;
    logic [WIDTH-1:0]   b_mag_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] z_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               neg_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] z_d;

    // Operand magnitudes at accept, one shift-add step, and the final sign fix-up.
    // The most negative operand negates to itself, which read as unsigned is its true magnitude.
    always_comb begin
        a_mag_d = (sign_i && multiplicand_i[WIDTH-1]) ? -multiplicand_i : multiplicand_i;
        b_mag_d = (sign_i && multiplier_i[WIDTH-1])   ? -multiplier_i   : multiplier_i;
        neg_d   = sign_i && (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1]);
        sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_mag_q[0] ? a_mag_q : {WIDTH{1'b0}})};
        acc_d   = {sum_d, acc_q[WIDTH-1:1]};
        z_d     = neg_q ? -acc_q : acc_q;
    end

    // Control FSM with datapath and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_mag_q <= a_mag_d;
                        b_mag_q <= b_mag_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    b_mag_q <= b_mag_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    z_q     <= z_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign z_o    = z_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed vectors with hand-computed products, back-to-back and reset-abort scenarios, random sweep.
// Latency: every operation must finish exactly 33 edges after its accept edge.
// Backpressure: start is held high in one scenario to check that busy-time requests are ignored.
module tb_mult_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        sign_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [63:0] z_o;
    logic        busy_o;
    logic        done_o;

    int n_chk;
    int n_bad;

    mult_seq #(.WIDTH(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .sign_i         (sign_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .z_o            (z_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        r;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            r  = sa * sb;
        end else begin
            r = {32'd0, a} * {32'd0, b};
        end
        return r;
    endfunction

    // Issue one operation from idle, scramble inputs after accept, check timing and result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        int lat;
        bit busy_ok;
        start_i        = 1'b1;
        sign_i         = s;
        multiplicand_i = a;
        multiplier_i   = b;
        @(posedge clk_i); #1;
        start_i        = 1'b0;
        sign_i         = ~s;
        multiplicand_i = $urandom;
        multiplier_i   = $urandom;
        busy_ok = (busy_o === 1'b1) && (done_o === 1'b0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) begin
                lat = k;
                break;
            end
            if (busy_o !== 1'b1) busy_ok = 0;
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy window"}, 64'(busy_ok), 64'd1);
        check({tag, " busy at done"}, 64'(busy_o), 64'd0);
        check({tag, " z"}, z_o, exp);
        @(posedge clk_i); #1;
        check({tag, " done width"}, 64'(done_o), 64'd0);
        check({tag, " z held"}, z_o, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] exp_z;
        bit          done_ok;

        n_chk = 0;
        n_bad = 0;
        rst_ni         = 1'b0;
        start_i        = 1'b0;
        sign_i         = 1'b0;
        multiplicand_i = '0;
        multiplier_i   = '0;

        // Reset state.
        #12;
        check("reset z", z_o, 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed vectors.
        run_op("4464x1 s",        32'd4464,      32'd1,         1'b1, 64'h00000000_00001170);
        run_op("4464xFFFFFFFF s", 32'd4464,      32'hFFFFFFFF,  1'b1, 64'hFFFFFFFF_FFFFEE90);
        run_op("4464xFFFFFFFF u", 32'd4464,      32'hFFFFFFFF,  1'b0, 64'h0000116F_FFFFEE90);
        run_op("minxmin s",       32'h80000000,  32'h80000000,  1'b1, 64'h40000000_00000000);
        run_op("maxxmax u",       32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE_00000001);
        run_op("7FFFFFFFx32 s",   32'h7FFFFFFF,  32'd32,        1'b1, 64'h0000000F_FFFFFFE0);
        run_op("0x32 s",          32'd0,         32'd32,        1'b1, 64'h0);
        run_op("minx1 u",         32'h80000000,  32'd1,         1'b0, 64'h00000000_80000000);
        run_op("minx1 s",         32'h80000000,  32'd1,         1'b1, 64'hFFFFFFFF_80000000);

        // Start held high with operands changing every cycle: accepts at 0, 34, 68.
        start_i        = 1'b1;
        sign_i         = 1'b1;
        multiplicand_i = 32'hFFFFFFF9;
        multiplier_i   = 32'd6;
        @(posedge clk_i); #1;
        exp_z   = 64'hFFFFFFFF_FFFFFFD6;
        done_ok = 1;
        for (int e = 1; e <= 101; e++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            sign_i         = rs;
            multiplicand_i = ra;
            multiplier_i   = rb;
            @(posedge clk_i); #1;
            if (e % 34 == 33) begin
                check("b2b done", 64'(done_o), 64'd1);
                check("b2b busy low", 64'(busy_o), 64'd0);
                check("b2b z", z_o, exp_z);
            end else begin
                if (done_o !== 1'b0) done_ok = 0;
                if (e % 34 == 0) begin
                    check("b2b reaccept busy", 64'(busy_o), 64'd1);
                    exp_z = ref_mul(ra, rb, rs);
                end
            end
        end
        start_i = 1'b0;
        @(posedge clk_i); #1;
        check("b2b done pulses", 64'(done_ok), 64'd1);
        check("b2b idle after", 64'(busy_o), 64'd0);

        // Reset 10 cycles into an operation aborts it without a clock edge.
        start_i        = 1'b1;
        sign_i         = 1'b1;
        multiplicand_i = 32'h12345678;
        multiplier_i   = 32'h9ABCDEF0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i); #1;
        end
        check("pre-abort busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("abort busy", 64'(busy_o), 64'd0);
        check("abort done", 64'(done_o), 64'd0);
        check("abort z", z_o, 64'd0);
        #1;
        rst_ni = 1'b1;
        run_op("post-reset AAAAAAAAx32 s", 32'hAAAAAAAA, 32'd32, 1'b1, 64'hFFFFFFF5_55555540);

        // Random operands against the 64-bit reference product.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rs, ref_mul(ra, rb, rs));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
